// File: rtl/serial_byte_rx.sv
// Serial byte receiver: start bit, 8 data bits MSB first, optional even parity.
// Define SERIAL_RX_PARITY_EN to add the trailing parity bit and PAR state.
module serial_byte_rx (
  input  logic [7:0] io_i,
  output logic [7:0] io_o
);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1
  } state_t;
`endif

  logic       clk;
  logic       rst;
  logic       sdata;
  logic       sen;
  logic       vsel;
  logic [2:0] rsvd_unused;

  assign clk         = io_i[0];
  assign rst         = io_i[1];
  assign sdata       = io_i[2];
  assign sen         = io_i[3];
  assign vsel        = io_i[4];
  assign rsvd_unused = io_i[7:5];

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic       valid_q, valid_d;
  logic       abort_q, abort_d;
  logic       perr;
  logic       busy;

`ifdef SERIAL_RX_PARITY_EN
  logic perr_q, perr_d;
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      fcnt_q  <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fcnt_q  <= fcnt_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fcnt_d  = fcnt_q;
    valid_d = valid_q;
    abort_d = abort_q;
`ifdef SERIAL_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (sen && sdata) begin
          state_d = DATA;
          cnt_d   = 3'd0;
        end
      end
      DATA: begin
        if (!sen) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          shift_d = {shift_q[6:0], sdata};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            data_d  = {shift_q[6:0], sdata};
            valid_d = 1'b1;
            abort_d = 1'b0;
            fcnt_d  = fcnt_q + 4'd1;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PAR: begin
        state_d = IDLE;
        if (!sen) begin
          abort_d = 1'b1;
        end else begin
          data_d  = shift_q;
          perr_d  = (^shift_q) ^ sdata;
          valid_d = 1'b1;
          abort_d = 1'b0;
          fcnt_d  = fcnt_q + 4'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  assign io_o = vsel ? {fcnt_q, abort_q, busy, perr, valid_q}
                     : data_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Randomized bench for serial_byte_rx against a frame-level model.
// Works with or without SERIAL_RX_PARITY_EN.
module tb_serial_byte_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sdata = 1'b0;
  logic       sen = 1'b0;
  logic       vsel = 1'b0;
  logic [2:0] rsv = 3'd0;
  logic [7:0] io_i;
  logic [7:0] io_o;

  int total = 0;
  int bad = 0;

  logic [7:0] m_data = 8'h00;
  logic [3:0] m_cnt = 4'd0;
  logic       m_valid = 1'b0;
  logic       m_abort = 1'b0;
  logic       m_perr = 1'b0;

  assign io_i = {rsv, vsel, sen, sdata, rst, clk};

  serial_byte_rx dut (
    .io_i(io_i),
    .io_o(io_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_now(input string tag, input bit busy);
    vsel = 1'b0;
    #1 check({tag, ".data"}, io_o, m_data);
    vsel = 1'b1;
    #1 check({tag, ".stat"}, io_o,
             {m_cnt, m_abort, busy, m_perr, m_valid});
  endtask

  task automatic drive(input bit s, input bit d);
    @(negedge clk);
    sen   = s;
    sdata = d;
    rsv   = 3'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sen     = 1'b0;
    rst     = 1'b1;
    m_data  = 8'h00;
    m_cnt   = 4'd0;
    m_valid = 1'b0;
    m_abort = 1'b0;
    m_perr  = 1'b0;
    check_now("rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ab: edge index (after start) where sen drops; -1 = full frame
  task automatic frame(input logic [7:0] b, input bit p, input int ab);
    drive(1'b1, 1'b1);
    check_now("pre", 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == ab) begin
        drive(1'b0, 1'($urandom));
        m_abort = 1'b1;
        return;
      end
      drive(1'b1, b[7-i]);
      if (i == 4) check_now("mid", 1'b1);
    end
`ifdef SERIAL_RX_PARITY_EN
    if (ab == 8) begin
      drive(1'b0, 1'($urandom));
      m_abort = 1'b1;
      return;
    end
    drive(1'b1, p);
    m_perr = (^b) ^ p;
`else
    if (p) m_perr = 1'b0;
`endif
    m_data  = b;
    m_valid = 1'b1;
    m_abort = 1'b0;
    m_cnt   = m_cnt + 4'd1;
  endtask

  initial begin
    logic [7:0] b;
    int         ab;
    int         gap;
    int         last;
`ifdef SERIAL_RX_PARITY_EN
    last = 8;
`else
    last = 7;
`endif
    #1 check("rst0.stat", io_o, 8'h00);
    do_reset();

    frame(8'hA5, 1'b0, -1);
    drive(1'b0, 1'b0);
    check_now("a5", 1'b0);
    check("a5.lit", io_o, 8'h11);
`ifdef SERIAL_RX_PARITY_EN
    frame(8'hA5, 1'b1, -1);
    drive(1'b0, 1'b0);
    check_now("a5p1", 1'b0);
    check("a5p1.lit", io_o, 8'h23);
`endif

    frame(8'h3C, 1'b0, 4);
    drive(1'b0, 1'b0);
    check_now("abort", 1'b0);

    frame(8'h01, 1'b1, -1);
    frame(8'h02, 1'b1, -1);
    drive(1'b0, 1'b0);
    check_now("b2b", 1'b0);

    drive(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom));
    do_reset();
    frame(8'h5A, 1'b0, -1);
    drive(1'b0, 1'b0);
    check_now("post_rst", 1'b0);
    check("post_rst.lit", io_o, 8'h11);

    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      frame(b, ^b, -1);
    end
    drive(1'b0, 1'b0);
    check_now("wrap", 1'b0);

    for (int n = 0; n < 60; n++) begin
      b  = 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, last) : -1;
      frame(b, 1'($urandom), ab);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 0) drive(1'b0, 1'($urandom));
        else drive(1'b1, 1'b0);
      end
    end
    drive(1'b0, 1'b0);
    check_now("end", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
